ram_4x4_arbiter: RTL

//  Two-port access controller for the ram_4x4 array (4 words x 4 bits, en/rdwr/clk interface).

---
 rtl/ram_4x4_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/ram_4x4_arbiter.sv
// ---------------------------------------------------------------------------
// ram_4x4_arbiter
//   Two-requester access controller for a ram_4x4 array (4 words x 4 bits).
//   It samples both requesters while idle, picks a winner, latches that
//   requester's command and runs one RAM access. Read data and a done pulse
//   go back to the winner. This block is the only driver of the RAM.
//
//   FSM: IDLE -> ACCESS -> DONE -> IDLE. Every output decodes from registers,
//   so there is no combinational path from the request inputs to any output.
//
//   Handshake: i_reqN is a level request. It is sampled only in IDLE. o_gntN
//   pulses for one cycle when the command has been latched. After that the
//   command inputs and i_reqN are ignored until the access has finished.
//   o_doneN pulses for one cycle when the access completes. A request that
//   is still high on the next IDLE cycle starts a new transaction.
//
// Configuration macro:
//   RAM_ARB_FIXED_PRI_EN - when defined, req0 always beats req1 and the
//                          round-robin pointer is removed. When it is
//                          undefined (the default), round-robin is used.
//
// Parameters:
//   DATA_W    - word width (matches ram_4x4 data_in/data_out)
//   ADDR_W    - address width (matches ram_4x4 ad_in)
//   WR_CYCLES - cycles that ram_en is held with ram_rdwr=0 per write (>=1)
//
// Ports:
//   i_clk, i_rst_n            clock (rising edge), async active-low reset
//   i_req0/1                  access request (level)
//   i_rw0/1                   1=read, 0=write
//   i_addr0/1, i_wdata0/1     command address / write data
//   o_gnt0/1                  one-cycle pulse: command latched
//   o_done0/1                 one-cycle pulse: access complete
//   o_rdata                   read data, updated only when a read completes
//   o_busy                    high in any state other than IDLE
//   o_ram_data_in/ad_in/en/rdwr  RAM drive
//   i_ram_data_out            RAM read data
//   o_dbg_state               current FSM state (0=IDLE 1=ACCESS 2=DONE)
// ---------------------------------------------------------------------------
module ram_4x4_arbiter #(
    parameter int DATA_W    = 4,
    parameter int ADDR_W    = 2,
    parameter int WR_CYCLES = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_rw0,
    input  logic              i_rw1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic              o_done0,
    output logic              o_done1,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_busy,
    output logic [DATA_W-1:0] o_ram_data_in,
    output logic [ADDR_W-1:0] o_ram_ad_in,
    output logic              o_ram_en,
    output logic              o_ram_rdwr,
    input  logic [DATA_W-1:0] i_ram_data_out,
    output logic [1:0]        o_dbg_state
);

    localparam int CNT_W = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_owner;      // 0: requester 0 owns the access, 1: requester 1
    logic              r_rw;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [CNT_W-1:0]  r_wr_cnt;
    logic              r_gnt0;
    logic              r_gnt1;
    logic              w_any_req;
    logic              w_win1;       // requester 1 wins this arbitration
    logic              w_grant;
    logic              w_wr_last;

    assign w_any_req = i_req0 | i_req1;
    assign w_grant   = (r_state == ST_IDLE) && w_any_req;
    assign w_wr_last = (r_wr_cnt == CNT_W'(WR_CYCLES - 1));

`ifdef RAM_ARB_FIXED_PRI_EN
    assign w_win1 = i_req1 & ~i_req0;
`else
    // r_pri1 is the round-robin pointer: set when requester 1 is favoured.
    // It points away from whichever requester was granted most recently.
    logic r_pri1;

    assign w_win1 = i_req1 & (~i_req0 | r_pri1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pri1 <= 1'b0;
        end else if (w_grant) begin
            r_pri1 <= ~w_win1;
        end
    end
`endif

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_any_req) w_state_next = ST_ACCESS;
            ST_ACCESS: if (r_rw || w_wr_last) w_state_next = ST_DONE;
            ST_DONE:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Command latch, grant pulse, write counter and read capture
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_owner  <= 1'b0;
            r_rw     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_wr_cnt <= '0;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
        end else begin
            r_gnt0 <= 1'b0;
            r_gnt1 <= 1'b0;
            if (w_grant) begin
                r_owner <= w_win1;
                r_gnt0  <= ~w_win1;
                r_gnt1  <= w_win1;
                r_rw    <= w_win1 ? i_rw1    : i_rw0;
                r_addr  <= w_win1 ? i_addr1  : i_addr0;
                r_wdata <= w_win1 ? i_wdata1 : i_wdata0;
            end
            if (r_state == ST_ACCESS && !r_rw) begin
                r_wr_cnt <= w_wr_last ? '0 : r_wr_cnt + CNT_W'(1);
            end else begin
                r_wr_cnt <= '0;
            end
            // A read is a single ACCESS cycle, so capture at the end of it.
            if (r_state == ST_ACCESS && r_rw) begin
                r_rdata <= i_ram_data_out;
            end
        end
    end

    // Output decode
    always_comb begin
        o_ram_en      = 1'b0;
        o_ram_rdwr    = 1'b0;
        o_ram_ad_in   = '0;
        o_ram_data_in = '0;
        o_done0       = 1'b0;
        o_done1       = 1'b0;
        if (r_state == ST_ACCESS) begin
            o_ram_en      = 1'b1;
            o_ram_rdwr    = r_rw;
            o_ram_ad_in   = r_addr;
            o_ram_data_in = r_wdata;
        end
        if (r_state == ST_DONE) begin
            o_done0 = ~r_owner;
            o_done1 = r_owner;
        end
        o_gnt0      = r_gnt0;
        o_gnt1      = r_gnt1;
        o_busy      = (r_state != ST_IDLE);
        o_rdata     = r_rdata;
        o_dbg_state = r_state;
    end

endmodule
